// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding select and hazard/stall generation from a shadow pipeline of in-flight producers.
// Define FWD_PERF_CNT_EN to add the stall_cycles / fwd_events performance counters.
module fwd_hazard_scoreboard #(
   parameter int DEPTH   = 2,
   parameter int NUM_SRC = 2,
   parameter int REG_AW  = 5,
   parameter int RDY_W   = 2,
   parameter int SEL_W   = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ex_valid,
   input  logic                       ex_kill,
   input  logic                       ex_regwrite,
   input  logic [REG_AW-1:0]          ex_rd,
   input  logic [RDY_W-1:0]           ex_rdy_stage,
   input  logic [NUM_SRC*REG_AW-1:0]  ex_rs,
   output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
   output logic [NUM_SRC-1:0]         hazard_mask,
   output logic                       stall
`ifdef FWD_PERF_CNT_EN
   ,
   output logic [31:0]                stall_cycles,
   output logic [31:0]                fwd_events
`endif
);

   localparam logic [RDY_W-1:0] RDY_MAX = RDY_W'(DEPTH-1);

   logic [DEPTH-1:0]  slot_valid;
   logic [REG_AW-1:0] slot_rd  [DEPTH];
   logic [RDY_W-1:0]  slot_rdy [DEPTH];

   logic [REG_AW-1:0] rs_k;
   logic [SEL_W-1:0]  sel_k;
   logic              hz_k;
   logic              ins_valid;
   logic [RDY_W-1:0]  ins_rdy;

   // Scan oldest to youngest so the youngest matching slot has the final say.
   always_comb begin
      fwd_sel     = '0;
      hazard_mask = '0;
      rs_k        = '0;
      sel_k       = '0;
      hz_k        = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         rs_k  = ex_rs[k*REG_AW +: REG_AW];
         sel_k = '0;
         hz_k  = 1'b0;
         for (int i = DEPTH-1; i >= 0; i--) begin
            if (slot_valid[i] && (slot_rd[i] == rs_k) && (rs_k != '0)) begin
               if (slot_rdy[i] <= RDY_W'(i)) begin
                  sel_k = SEL_W'(i+1);
                  hz_k  = 1'b0;
               end else begin
                  sel_k = '0;
                  hz_k  = 1'b1;
               end
            end
         end
         fwd_sel[k*SEL_W +: SEL_W] = sel_k;
         hazard_mask[k]            = hz_k;
      end
   end

   assign stall     = ex_valid & (|hazard_mask);
   assign ins_valid = ~stall & ex_valid & ~ex_kill & ex_regwrite & (ex_rd != '0);
   assign ins_rdy   = (ex_rdy_stage > RDY_MAX) ? RDY_MAX : ex_rdy_stage;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_valid <= '0;
      end else begin
         slot_valid[0] <= ins_valid;
         for (int i = 1; i < DEPTH; i++) begin
            slot_valid[i] <= slot_valid[i-1];
         end
      end
   end

   // Payload is only meaningful alongside its valid bit, so it carries no reset.
   always_ff @(posedge clk) begin
      slot_rd[0]  <= ex_rd;
      slot_rdy[0] <= ins_rdy;
      for (int i = 1; i < DEPTH; i++) begin
         slot_rd[i]  <= slot_rd[i-1];
         slot_rdy[i] <= slot_rdy[i-1];
      end
   end

`ifdef FWD_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         fwd_events   <= '0;
      end else begin
         if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if ((|fwd_sel) && !stall && (fwd_events != '1)) begin
            fwd_events <= fwd_events + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Self-checking bench for fwd_hazard_scoreboard: directed scenarios plus random traffic
// checked by a queue-of-producers reference model through a decoupled scoreboard monitor.
module tb_fwd_hazard_scoreboard;

   localparam int DEPTH   = 4;
   localparam int NUM_SRC = 2;
   localparam int REG_AW  = 5;
   localparam int RDY_W   = 3;
   localparam int SEL_W   = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid, ex_kill, ex_regwrite;
   logic [4:0]  ex_rd;
   logic [2:0]  ex_rdy_stage;
   logic [9:0]  ex_rs;
   logic [5:0]  fwd_sel;
   logic [1:0]  hazard_mask;
   logic        stall;
`ifdef FWD_PERF_CNT_EN
   logic [31:0] stall_cycles, fwd_events;
`endif

   always #5 clk = ~clk;

   fwd_hazard_scoreboard #(
      .DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .RDY_W(RDY_W), .SEL_W(SEL_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_kill(ex_kill),
      .ex_regwrite(ex_regwrite), .ex_rd(ex_rd), .ex_rdy_stage(ex_rdy_stage),
      .ex_rs(ex_rs), .fwd_sel(fwd_sel), .hazard_mask(hazard_mask), .stall(stall)
`ifdef FWD_PERF_CNT_EN
      , .stall_cycles(stall_cycles), .fwd_events(fwd_events)
`endif
   );

   typedef struct { logic v; logic [4:0] rd; int rdy; } prod_t;
   typedef struct {
      logic [5:0]  sel;
      logic [1:0]  hm;
      logic        st;
      logic [31:0] sc;
      logic [31:0] fe;
   } exp_t;

   prod_t       hist[$];   // index j = producer that left EX j+1 cycles ago
   prod_t       pend;
   exp_t        exq[$];
   exp_t        last;
   exp_t        mon_e;
   logic [31:0] exp_sc, exp_fe;
   int          vectors = 0;
   int          miscompares = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic exp_t predict(input logic v, input logic [4:0] rs0, input logic [4:0] rs1);
      exp_t       e;
      logic [4:0] rs;
      e = '{default: '0};
      for (int k = 0; k < 2; k++) begin
         rs = (k == 0) ? rs0 : rs1;
         for (int j = 0; j < hist.size(); j++) begin
            if (hist[j].v && hist[j].rd == rs && rs != 5'd0) begin
               if (hist[j].rdy <= j) e.sel[k*3 +: 3] = 3'(j+1);
               else                  e.hm[k] = 1'b1;
               break;
            end
         end
      end
      e.st = v && (e.hm != 2'b00);
      e.sc = exp_sc;
      e.fe = exp_fe;
      return e;
   endfunction

   task automatic cyc(input logic v, input logic k, input logic rw, input logic [4:0] rd,
                      input logic [2:0] rdy, input logic [4:0] rs0, input logic [4:0] rs1);
      @(posedge clk);
      #1;
      hist.push_front(pend);
      if (hist.size() > DEPTH) void'(hist.pop_back());
      if (last.st && exp_sc != 32'hffff_ffff) exp_sc++;
      if (last.sel != 6'd0 && !last.st && exp_fe != 32'hffff_ffff) exp_fe++;
      ex_valid = v; ex_kill = k; ex_regwrite = rw; ex_rd = rd;
      ex_rdy_stage = rdy; ex_rs = {rs1, rs0};
      last = predict(v, rs0, rs1);
      exq.push_back(last);
      pend.v   = !last.st && v && !k && rw && (rd != 5'd0);
      pend.rd  = rd;
      pend.rdy = (int'(rdy) > DEPTH-1) ? DEPTH-1 : int'(rdy);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 5'd0, 5'd0);
   endtask

   task automatic clear_model();
      hist.delete();
      pend   = '{v: 1'b0, rd: 5'd0, rdy: 0};
      last   = '{default: '0};
      exp_sc = '0;
      exp_fe = '0;
   endtask

   // Monitor: compares every presented cycle against the queued expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (exq.size() > 0) begin
            mon_e = exq.pop_front();
            check("fwd_sel", 32'(fwd_sel), 32'(mon_e.sel));
            check("hazard_mask", 32'(hazard_mask), 32'(mon_e.hm));
            check("stall", 32'(stall), 32'(mon_e.st));
`ifdef FWD_PERF_CNT_EN
            check("stall_cycles", stall_cycles, mon_e.sc);
            check("fwd_events", fwd_events, mon_e.fe);
`endif
         end
      end
   end

   int         nst;
   logic       rv, rk, rw;
   logic [4:0] rd, rs0, rs1;
   logic [2:0] rdy;

   initial begin
      clear_model();
      ex_valid = 1'b1; ex_kill = 1'b0; ex_regwrite = 1'b1; ex_rd = 5'd3;
      ex_rdy_stage = 3'd0; ex_rs = {5'd3, 5'd3};
      repeat (3) @(posedge clk);
      #2;
      check("reset_fwd_sel", 32'(fwd_sel), 32'd0);
      check("reset_hazard", 32'(hazard_mask), 32'd0);
      check("reset_stall", 32'(stall), 32'd0);
      ex_valid = 1'b0;
      #1 rst_n = 1'b1;

      // ALU producer forwarded from MEM then WB
      cyc(1, 0, 1, 5'd5, 3'd0, 5'd0, 5'd0);
      cyc(1, 0, 0, 5'd0, 3'd0, 5'd5, 5'd0);
      check("alu_fwd_mem", 32'(fwd_sel[2:0]), 32'd1);
      check("alu_no_stall", 32'(stall), 32'd0);
      cyc(1, 0, 0, 5'd0, 3'd0, 5'd5, 5'd0);
      check("alu_fwd_wb", 32'(fwd_sel[2:0]), 32'd2);
      idle(4);

      // load-use: exactly one stall on operand 1
      cyc(1, 0, 1, 5'd6, 3'd1, 5'd0, 5'd0);
      cyc(1, 0, 0, 5'd0, 3'd0, 5'd0, 5'd6);
      check("load_use_stall", 32'(stall), 32'd1);
      check("load_use_mask", 32'(hazard_mask), 32'b10);
      cyc(1, 0, 0, 5'd0, 3'd0, 5'd0, 5'd6);
      check("load_use_release", 32'(stall), 32'd0);
      check("load_use_fwd", 32'(fwd_sel[5:3]), 32'd2);
      idle(4);

      // youngest writer wins
      cyc(1, 0, 1, 5'd7, 3'd0, 5'd0, 5'd0);
      cyc(1, 0, 1, 5'd7, 3'd0, 5'd0, 5'd0);
      cyc(1, 0, 0, 5'd0, 3'd0, 5'd7, 5'd0);
      check("youngest_wins", 32'(fwd_sel[2:0]), 32'd1);
      idle(4);

      // x0 never forwarded; killed producer never inserted
      cyc(1, 0, 1, 5'd0, 3'd0, 5'd0, 5'd0);
      cyc(1, 0, 0, 5'd0, 3'd0, 5'd0, 5'd0);
      check("x0_fwd", 32'(fwd_sel), 32'd0);
      check("x0_stall", 32'(stall), 32'd0);
      idle(4);
      cyc(1, 1, 1, 5'd9, 3'd0, 5'd0, 5'd0);
      cyc(1, 0, 0, 5'd0, 3'd0, 5'd9, 5'd9);
      check("killed_fwd", 32'(fwd_sel), 32'd0);
      idle(4);

      // long latency: rdy 3 gives 3 stalls then forward from slot 3
      cyc(1, 0, 1, 5'd10, 3'd3, 5'd0, 5'd0);
      cyc(1, 0, 0, 5'd0, 3'd0, 5'd10, 5'd0);
      nst = 0;
      while (stall && nst < 10) begin
         nst++;
         cyc(1, 0, 0, 5'd0, 3'd0, 5'd10, 5'd0);
      end
      check("rdy3_stalls", 32'(nst), 32'd3);
      check("rdy3_fwd", 32'(fwd_sel[2:0]), 32'd4);
      idle(4);

      // rdy 7 clamps to DEPTH-1 = 3
      cyc(1, 0, 1, 5'd12, 3'd7, 5'd0, 5'd0);
      cyc(1, 0, 0, 5'd0, 3'd0, 5'd0, 5'd12);
      nst = 0;
      while (stall && nst < 10) begin
         nst++;
         cyc(1, 0, 0, 5'd0, 3'd0, 5'd0, 5'd12);
      end
      check("clamp_stalls", 32'(nst), 32'd3);
      check("clamp_fwd", 32'(fwd_sel[5:3]), 32'd4);
      idle(4);

      // kill does not mask a hazard
      cyc(1, 0, 1, 5'd11, 3'd1, 5'd0, 5'd0);
      cyc(1, 1, 0, 5'd0, 3'd0, 5'd11, 5'd0);
      check("kill_hazard_stall", 32'(stall), 32'd1);
      check("kill_hazard_mask", 32'(hazard_mask), 32'b01);
      idle(4);

      // reset in the middle of a load-use stall
      cyc(1, 0, 1, 5'd8, 3'd1, 5'd0, 5'd0);
      cyc(1, 0, 0, 5'd0, 3'd0, 5'd8, 5'd0);
      check("pre_reset_stall", 32'(stall), 32'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_reset_stall", 32'(stall), 32'd0);
      check("mid_reset_fwd", 32'(fwd_sel), 32'd0);
      ex_valid = 1'b0; ex_regwrite = 1'b0;
      clear_model();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      ex_valid = 1'b1; ex_rs = {5'd8, 5'd8};
      #1;
      check("post_reset_fwd", 32'(fwd_sel), 32'd0);
      check("post_reset_stall", 32'(stall), 32'd0);
`ifdef FWD_PERF_CNT_EN
      check("post_reset_sc", stall_cycles, 32'd0);
      check("post_reset_fe", fwd_events, 32'd0);
`endif

      // random traffic; a stalled EX usually holds its instruction
      rv = 0; rk = 0; rw = 0; rd = 0; rdy = 0; rs0 = 0; rs1 = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!(last.st && $urandom_range(0, 3) != 0)) begin
            rv  = ($urandom_range(0, 9) != 0);
            rk  = ($urandom_range(0, 9) == 0);
            rw  = ($urandom_range(0, 4) != 0);
            rd  = 5'($urandom_range(0, 7));
            rdy = 3'($urandom_range(0, 7));
            rs0 = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
         end
         cyc(rv, rk, rw, rd, rdy, rs0, rs1);
      end

      @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(exq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
